trivium_stream_ctrl: RTL and testbench

Sequencer that owns a single Trivium keystream core (clk, active-low rst, enable, registered keystream_bit) and turns it into a byte-wide stream cipher engine. It resets the core, runs the warm-up phase, and then packs eight keystream bits per accepted plaintext byte. It XORs the packed keystream with the input byte and returns the result over a valid/ready handshake. It sits between the core and the byte-wide data path. The key and IV stay core parameters; this block only sequences the core.

---
 rtl/trivium_stream_ctrl_if.sv | 20 ++
 rtl/trivium_stream_ctrl.sv | 98 +++++++++
 tb/tb_trivium_stream_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trivium_stream_ctrl_if.sv
// Byte-wide plaintext-in / result-out valid-ready bundle around the Trivium sequencer.
// The slave side is the sequencer; the master side is the surrounding data path.
interface trivium_stream_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/trivium_stream_ctrl.sv
// Sequences one Trivium core: reset, warm-up, then 8 keystream bits XORed per accepted byte.
// Accept-to-out_valid 9 cycles; one byte in flight; result held in OUT until out_ready.
module trivium_stream_ctrl #(
   parameter int WARMUP_CYCLES = 1153,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             core_rst,
   output logic             core_en,
   input  logic             ks_bit,
   output logic             busy,
   output logic [CNT_W-1:0] byte_count,
   trivium_stream_ctrl_if.slave strm
);

   typedef enum logic [2:0] {IDLE, CRST, WARM, READY, GATHER, DRAIN, OUT} state_t;

   localparam logic [10:0] WARM_LAST = 11'(WARMUP_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [10:0] warm_cnt;
   logic [2:0]  bit_cnt;
   logic [6:0]  ks_sr;
   logic [7:0]  data_q;
   logic        accept;
   logic        deliver;

   // start outranks a same-cycle byte offer, so the byte is never taken.
   assign accept  = strm.in_valid & strm.in_ready & ~start;
   assign deliver = strm.out_valid & strm.out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         CRST:    state_nxt = WARM;
         WARM:    if (warm_cnt == WARM_LAST) state_nxt = READY;
         READY:   if (accept) state_nxt = GATHER;
         GATHER:  if (bit_cnt == 3'd7) state_nxt = DRAIN;
         DRAIN:   state_nxt = OUT;
         OUT:     if (deliver) state_nxt = READY;
         default: state_nxt = IDLE;
      endcase
      if (start) state_nxt = CRST;
   end

   // Outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         core_rst      <= 1'b1;
         core_en       <= 1'b0;
         strm.in_ready <= 1'b0;
         strm.out_valid <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state          <= state_nxt;
         core_rst       <= (state_nxt != CRST);
         core_en        <= (state_nxt == WARM) || (state_nxt == GATHER);
         strm.in_ready  <= (state_nxt == READY);
         strm.out_valid <= (state_nxt == OUT);
         busy           <= (state_nxt != IDLE) && (state_nxt != READY);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         warm_cnt      <= '0;
         bit_cnt       <= '0;
         ks_sr         <= '0;
         data_q        <= '0;
         byte_count    <= '0;
         strm.out_data <= '0;
      end else begin
         case (state)
            CRST: begin
               warm_cnt   <= '0;
               bit_cnt    <= '0;
               byte_count <= '0;
            end
            WARM: warm_cnt <= warm_cnt + 11'd1;
            READY: if (accept) data_q <= strm.in_data;
            GATHER: begin
               // ks_bit lags core_en by one edge: g1..g7 carry bits 0..6.
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt != 3'd0) ks_sr <= {ks_bit, ks_sr[6:1]};
            end
            DRAIN: strm.out_data <= data_q ^ {ks_bit, ks_sr};
            OUT: if (deliver && !start) byte_count <= byte_count + CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Directed bench for trivium_stream_ctrl with a behavioural keystream stub whose bit k
// (produced by the k-th enable since core reset) is chosen by the current pattern mode.
module tb_trivium_stream_ctrl;
   localparam int W  = 1153;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          core_rst;
   logic          core_en;
   logic          ks_bit = 1'b0;
   logic          busy;
   logic [CW-1:0] byte_count;

   trivium_stream_ctrl_if bus();

   trivium_stream_ctrl #(.WARMUP_CYCLES(W), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .core_rst   (core_rst),
      .core_en    (core_en),
      .ks_bit     (ks_bit),
      .busy       (busy),
      .byte_count (byte_count),
      .strm       (bus)
   );

   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int mode     = 0;
   int en_n     = 0;

   function automatic logic pat(input int k);
      logic [31:0] h;
      h = 32'(k) * 32'h9E3779B1;
      case (mode)
         0:       return 1'b1;
         1:       return (k > W) && (((k - W - 1) % 8) == 0);
         default: return ^h[31:16];
      endcase
   endfunction

   // Expected keystream byte j after warm-up, packed LSB-first.
   function automatic logic [7:0] ks_byte(input int j);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = pat(W + 8*j + 1 + i);
      return b;
   endfunction

   // Stub core: registered bit, updated at the edge ending each enabled cycle.
   always @(posedge clk) begin
      if (!core_rst) begin
         en_n   <= 0;
         ks_bit <= 1'b0;
      end else if (core_en) begin
         en_n   <= en_n + 1;
         ks_bit <= pat(en_n + 1);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_ready(input string tag, output int en_seen, output bit ov_seen);
      bit ok;
      ok = 1'b0;
      en_seen = 0;
      ov_seen = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         if (bus.in_ready) ok = 1'b1;
         else begin
            if (core_en) en_seen++;
            if (bus.out_valid) ov_seen = 1'b1;
            @(negedge clk);
         end
      end
      check({tag, "_ready"}, ok, 1);
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] exp, input int hold,
                       input string tag, output logic [7:0] got);
      int lat;
      bit stable;
      check({tag, "_rdy"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, 9);
      got = bus.out_data;
      check({tag, "_dat"}, got, exp);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_data !== got || bus.in_ready || core_en) stable = 1'b0;
      end
      if (hold > 0) check({tag, "_hold"}, stable, 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int         n;
      bit         ov;
      bit         en_any;
      logic [7:0] r;
      logic [7:0] ct [16];

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;

      #12;
      check("rst_core_rst", core_rst, 1);
      check("rst_core_en", core_en, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_byte_count", byte_count, 0);
      @(negedge clk);
      rst = 1'b1;

      en_any = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (core_en) en_any = 1'b1;
      end
      check("idle_en", en_any, 0);
      check("idle_busy", busy, 0);

      // Start sequencing: one CRST cycle, then a contiguous warm-up run.
      pulse_start;
      check("crst_low", core_rst, 0);
      check("crst_en", core_en, 0);
      check("crst_busy", busy, 1);
      @(negedge clk);
      check("crst_one_cycle", core_rst, 1);
      wait_ready("warm1", n, ov);
      check("warm1_len", n, W);
      check("warm1_core_cnt", en_n, W);
      check("ready_busy", busy, 0);

      send(8'hA5, 8'h5A, 0, "xor_a5", r);
      check("cnt_after_a5", byte_count, 1);
      send(8'h3C, 8'hC3, 20, "bp", r);
      check("bp_cnt", byte_count, 2);

      mode = 1;
      send(8'h00, 8'h01, 0, "order0", r);
      send(8'hF0, 8'hF1, 0, "order1", r);
      check("cnt_after_order", byte_count, 4);

      // Abort during GATHER g4.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("g4_core_en", core_en, 1);
      pulse_start;
      check("abort_crst", core_rst, 0);
      wait_ready("abort", n, ov);
      check("abort_warm_len", n, W);
      check("abort_no_out", ov, 0);
      check("abort_cnt", byte_count, 0);

      // Abort while holding a result in OUT.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("out_reached", bus.out_valid, 1);
      pulse_start;
      check("out_drop", bus.out_valid, 0);
      wait_ready("rearm_out", n, ov);
      check("rearm_out_len", n, W);

      // start and in_valid together in READY: the byte is dropped.
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      @(negedge clk);
      start        = 1'b0;
      bus.in_valid = 1'b0;
      check("collide_crst", core_rst, 0);
      wait_ready("collide", n, ov);
      check("collide_no_out", ov, 0);
      check("collide_warm_len", n, W);

      mode = 2;
      for (int j = 0; j < 16; j++) send(8'h00, ks_byte(j), 0, $sformatf("ks%0d", j), ct[j]);
      check("cnt_16_wrap", byte_count, 0);
      send(8'h11, 8'h11 ^ ks_byte(16), 0, "ks16", r);
      check("cnt_17_wrap", byte_count, 1);

      pulse_start;
      wait_ready("redo", n, ov);
      for (int j = 0; j < 16; j++) send(ct[j], 8'h00, 0, $sformatf("dec%0d", j), r);

      // Asynchronous reset in the middle of warm-up.
      pulse_start;
      repeat (50) @(negedge clk);
      check("warm_mid_en", core_en, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_en", core_en, 0);
      check("arst_busy", busy, 0);
      check("arst_core_rst", core_rst, 1);
      @(negedge clk);
      rst = 1'b1;
      en_any = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (core_en || busy) en_any = 1'b1;
      end
      check("arst_stays_idle", en_any, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
